// File: rtl/iter_alu_pkg.sv
// rtl/iter_alu_pkg.sv - shared opcodes, FSM states and mask helper for iter_alu
package iter_alu_pkg;

  localparam logic [3:0] OP_NOT  = 4'd0;
  localparam logic [3:0] OP_AND  = 4'd1;
  localparam logic [3:0] OP_OR   = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd3;
  localparam logic [3:0] OP_ADD  = 4'd4;
  localparam logic [3:0] OP_ADC  = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_SBC  = 4'd7;
  localparam logic [3:0] OP_INC  = 4'd8;
  localparam logic [3:0] OP_DEC  = 4'd9;
  localparam logic [3:0] OP_SHL  = 4'd10;
  localparam logic [3:0] OP_SHR  = 4'd11;
  localparam logic [3:0] OP_ROL  = 4'd12;
  localparam logic [3:0] OP_ROR  = 4'd13;
  localparam logic [3:0] OP_CMP  = 4'd14;
  localparam logic [3:0] OP_CLRF = 4'd15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Widest datapath the mask helper can describe; users narrow it with a cast.
  localparam int MASK_MAX_W = 64;

  // Ones in the low width/2 bits: selects the half-word lane.
  function automatic logic [MASK_MAX_W-1:0] half_mask(input int width);
    logic [MASK_MAX_W-1:0] m;
    m = '0;
    for (int i = 0; i < MASK_MAX_W; i++) begin
      if (i < width / 2) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/iter_alu_addsub.sv
// rtl/iter_alu_addsub.sv - mode-aware adder/subtractor with carry or borrow in/out
module iter_alu_addsub
  import iter_alu_pkg::*;
#(
  parameter int WIDTH = 20
) (
  input  logic             mode,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int H = WIDTH / 2;
  localparam logic [WIDTH-1:0] HALF_MASK = WIDTH'(half_mask(WIDTH));

  logic [WIDTH:0] raw;

  // Operands arrive already masked to the active width, so one WIDTH+1 wide
  // operation serves both modes; the carry/borrow is read one bit above the
  // active MSB (a negative difference sets every bit from there upward).
  always_comb begin
    raw = '0;
    if (sub) raw = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
    else     raw = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  end

  assign sum  = mode ? raw[WIDTH-1:0] : (raw[WIDTH-1:0] & HALF_MASK);
  assign cout = mode ? raw[WIDTH] : raw[H];

endmodule

// File: rtl/iter_alu.sv
// rtl/iter_alu.sv - clocked ALU with iterative shifts and persistent Z/S/C status
module iter_alu
  import iter_alu_pkg::*;
#(
  parameter int WIDTH   = 20,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         op,
  input  logic               mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               flag_zero,
  output logic               flag_sign,
  output logic               flag_carry,
  output logic               busy
);

  localparam int H = WIDTH / 2;
  localparam logic [WIDTH-1:0] HALF_MASK = WIDTH'(half_mask(WIDTH));
  localparam logic [WIDTH-1:0] FULL_TOP  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] HALF_TOP  = {{(WIDTH-H){1'b0}}, 1'b1, {(H-1){1'b0}}};

  state_t             state;
  logic [3:0]         op_q;
  logic               mode_q;
  logic [WIDTH-1:0]   sh_q;
  logic [SHAMT_W-1:0] cnt_q;

  logic [WIDTH-1:0] in_mask, a_m, b_m;
  logic             accept, is_shift;

  logic             as_sub, as_cin, as_cout;
  logic [WIDTH-1:0] as_b, as_sum;

  logic [WIDTH-1:0] imm_res, imm_flag_src;
  logic             imm_c;

  logic [WIDTH-1:0] q_mask, step_res;
  logic             q_msb, step_c;

  function automatic logic msb_of(input logic [WIDTH-1:0] v, input logic m);
    return m ? v[WIDTH-1] : v[H-1];
  endfunction

  assign in_mask  = mode ? {WIDTH{1'b1}} : HALF_MASK;
  assign a_m      = a & in_mask;
  assign b_m      = b & in_mask;
  assign accept   = in_valid & in_ready;
  assign is_shift = (op >= OP_SHL) && (op <= OP_ROR);

  // Steer the shared adder: ADC/SBC chain through the stored carry, INC/DEC use a fixed 1.
  always_comb begin
    as_sub = 1'b0;
    as_b   = b_m;
    as_cin = 1'b0;
    case (op)
      OP_ADC: as_cin = flag_carry;
      OP_SUB: as_sub = 1'b1;
      OP_SBC: begin as_sub = 1'b1; as_cin = flag_carry; end
      OP_INC: begin as_b = '0; as_cin = 1'b1; end
      OP_DEC: begin as_sub = 1'b1; as_b = '0; as_cin = 1'b1; end
      OP_CMP: as_sub = 1'b1;
      default: ;
    endcase
  end

  iter_alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .mode (mode),
    .sub  (as_sub),
    .a    (a_m),
    .b    (as_b),
    .cin  (as_cin),
    .sum  (as_sum),
    .cout (as_cout)
  );

  // Single-cycle result for everything that does not iterate (incl. shamt = 0 shifts).
  always_comb begin
    imm_res = a_m;
    imm_c   = flag_carry;
    case (op)
      OP_NOT: imm_res = ~a_m & in_mask;
      OP_AND: imm_res = a_m & b_m;
      OP_OR:  imm_res = a_m | b_m;
      OP_XOR: imm_res = a_m ^ b_m;
      OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_INC, OP_DEC: begin
        imm_res = as_sum;
        imm_c   = as_cout;
      end
      OP_CMP:  imm_c = as_cout;
      OP_CLRF: begin imm_res = '0; imm_c = 1'b0; end
      default: ;
    endcase
  end

  // CMP keeps a as the result but derives Z/S from the difference.
  assign imm_flag_src = (op == OP_CMP) ? as_sum : imm_res;

  // One-bit shift/rotate step applied to the captured operand each SHIFT cycle.
  always_comb begin
    q_mask   = mode_q ? {WIDTH{1'b1}} : HALF_MASK;
    q_msb    = msb_of(sh_q, mode_q);
    step_res = sh_q;
    step_c   = flag_carry;
    case (op_q)
      OP_SHL: begin
        step_res = (sh_q << 1) & q_mask;
        step_c   = q_msb;
      end
      OP_SHR: begin
        step_res = sh_q >> 1;
        step_c   = sh_q[0];
      end
      OP_ROL: begin
        step_res = ((sh_q << 1) | {{(WIDTH-1){1'b0}}, q_msb}) & q_mask;
        step_c   = q_msb;
      end
      OP_ROR: begin
        step_res = (sh_q >> 1) | (sh_q[0] ? (mode_q ? FULL_TOP : HALF_TOP) : '0);
        step_c   = sh_q[0];
      end
      default: ;
    endcase
  end

  // Control FSM with registered handshake, result and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      result     <= '0;
      flag_zero  <= 1'b0;
      flag_sign  <= 1'b0;
      flag_carry <= 1'b0;
      op_q       <= OP_NOT;
      mode_q     <= 1'b0;
      sh_q       <= '0;
      cnt_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q     <= op;
            mode_q   <= mode;
            sh_q     <= a_m;
            cnt_q    <= shamt;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (is_shift && (shamt != '0)) begin
              state <= SHIFT;
            end else begin
              state      <= DONE;
              out_valid  <= 1'b1;
              result     <= imm_res;
              flag_zero  <= (op != OP_CLRF) && (imm_flag_src == '0);
              flag_sign  <= msb_of(imm_flag_src, mode);
              flag_carry <= imm_c;
            end
          end
        end
        SHIFT: begin
          sh_q  <= step_res;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == SHAMT_W'(1)) begin
            state      <= DONE;
            out_valid  <= 1'b1;
            result     <= step_res;
            flag_zero  <= (step_res == '0);
            flag_sign  <= msb_of(step_res, mode_q);
            flag_carry <= step_c;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_alu.sv
// tb/tb_iter_alu.sv - directed self-checking bench for iter_alu
module tb_iter_alu;
  import iter_alu_pkg::*;

  logic        clk, rst_n, in_valid, in_ready, mode, out_valid, out_ready;
  logic        flag_zero, flag_sign, flag_carry, busy;
  logic [3:0]  op;
  logic [19:0] a, b, result;
  logic [4:0]  shamt;

  int n_vec = 0;
  int n_err = 0;

  iter_alu #(.WIDTH(20), .SHAMT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .mode(mode), .a(a), .b(b), .shamt(shamt),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .flag_zero(flag_zero), .flag_sign(flag_sign), .flag_carry(flag_carry),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input logic [3:0] o, input logic m, input logic [19:0] aa,
                           input logic [19:0] bb, input logic [4:0] sa);
    op = o; mode = m; a = aa; b = bb; shamt = sa; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = 20'hABCDE; b = 20'h13579;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_vec++;
    if ({in_ready, out_valid, busy, result, flag_zero, flag_sign, flag_carry} !== {3'b100, 20'h0, 3'b000}) begin
      n_err++;
      $display("FAIL reset_state: got %h expected %h",
               {in_ready, out_valid, busy, result, flag_zero, flag_sign, flag_carry}, {3'b100, 20'h0, 3'b000});
    end
  endtask

  task automatic test_add_adc();
    int lat;
    start_req(OP_ADD, 1'b1, 20'hFFFFF, 20'h00001, 5'd0);
    wait_done(lat);
    n_vec++;
    if ({lat, result, flag_zero, flag_sign, flag_carry} !== {32'd1, 20'h00000, 3'b101}) begin
      n_err++;
      $display("FAIL add_wrap: lat %0d res %h zsc %b expected lat 1 res 00000 zsc 101", lat, result, {flag_zero, flag_sign, flag_carry});
    end
    consume();
    start_req(OP_ADC, 1'b1, 20'h00001, 20'h00001, 5'd0);
    wait_done(lat);
    n_vec++;
    if ({result, flag_zero, flag_sign, flag_carry} !== {20'h00003, 3'b000}) begin
      n_err++;
      $display("FAIL adc_chain: res %h zsc %b expected res 00003 zsc 000", result, {flag_zero, flag_sign, flag_carry});
    end
    consume();
  endtask

  task automatic test_half_sub();
    int lat;
    start_req(OP_SUB, 1'b0, 20'hFF005, 20'h00007, 5'd0);
    wait_done(lat);
    n_vec++;
    if ({result, flag_zero, flag_sign, flag_carry} !== {20'h003FE, 3'b011}) begin
      n_err++;
      $display("FAIL half_sub: res %h zsc %b expected res 003FE zsc 011", result, {flag_zero, flag_sign, flag_carry});
    end
    consume();
    start_req(OP_SBC, 1'b1, 20'h00010, 20'h00005, 5'd0);
    wait_done(lat);
    n_vec++;
    if ({result, flag_zero, flag_sign, flag_carry} !== {20'h0000A, 3'b000}) begin
      n_err++;
      $display("FAIL sbc_borrow_in: res %h zsc %b expected res 0000A zsc 000", result, {flag_zero, flag_sign, flag_carry});
    end
    consume();
  endtask

  task automatic test_dec_not_clrf();
    int lat;
    start_req(OP_DEC, 1'b1, 20'h00000, 20'h00000, 5'd0);
    wait_done(lat);
    n_vec++;
    if ({result, flag_zero, flag_sign, flag_carry} !== {20'hFFFFF, 3'b011}) begin
      n_err++;
      $display("FAIL dec_zero: res %h zsc %b expected res FFFFF zsc 011", result, {flag_zero, flag_sign, flag_carry});
    end
    consume();
    start_req(OP_NOT, 1'b0, 20'h00F0F, 20'h00000, 5'd0);
    wait_done(lat);
    n_vec++;
    if ({result, flag_zero, flag_sign, flag_carry} !== {20'h000F0, 3'b001}) begin
      n_err++;
      $display("FAIL half_not_keeps_c: res %h zsc %b expected res 000F0 zsc 001", result, {flag_zero, flag_sign, flag_carry});
    end
    consume();
    start_req(OP_CLRF, 1'b1, 20'h12345, 20'h00000, 5'd0);
    wait_done(lat);
    n_vec++;
    if ({result, flag_zero, flag_sign, flag_carry} !== {20'h00000, 3'b000}) begin
      n_err++;
      $display("FAIL clrf: res %h zsc %b expected res 00000 zsc 000", result, {flag_zero, flag_sign, flag_carry});
    end
    consume();
  endtask

  task automatic test_rotate();
    start_req(OP_ROL, 1'b1, 20'h80001, 20'h00000, 5'd3);
    for (int k = 1; k <= 3; k++) begin
      n_vec++;
      if ({busy, out_valid, in_ready} !== 3'b100) begin
        n_err++;
        $display("FAIL rol_busy_cycle%0d: busy/ov/ir %b expected 100", k, {busy, out_valid, in_ready});
      end
      tick();
    end
    n_vec++;
    if ({out_valid, busy, result, flag_zero, flag_sign, flag_carry} !== {2'b11, 20'h0000C, 3'b000}) begin
      n_err++;
      $display("FAIL rol3_done: ov %b busy %b res %h zsc %b expected ov 1 busy 1 res 0000C zsc 000",
               out_valid, busy, result, {flag_zero, flag_sign, flag_carry});
    end
    consume();
  endtask

  task automatic test_long_shifts();
    int lat;
    start_req(OP_SHL, 1'b1, 20'h00001, 20'h00000, 5'd20);
    wait_done(lat);
    n_vec++;
    if ({lat, result, flag_zero, flag_sign, flag_carry} !== {32'd21, 20'h00000, 3'b101}) begin
      n_err++;
      $display("FAIL shl_by_width: lat %0d res %h zsc %b expected lat 21 res 00000 zsc 101", lat, result, {flag_zero, flag_sign, flag_carry});
    end
    consume();
    start_req(OP_ROR, 1'b0, 20'h00001, 20'h00000, 5'd11);
    wait_done(lat);
    n_vec++;
    if ({lat, result, flag_zero, flag_sign, flag_carry} !== {32'd12, 20'h00200, 3'b011}) begin
      n_err++;
      $display("FAIL half_ror_wrap: lat %0d res %h zsc %b expected lat 12 res 00200 zsc 011", lat, result, {flag_zero, flag_sign, flag_carry});
    end
    consume();
    start_req(OP_SHR, 1'b0, 20'hFFFFF, 20'h00000, 5'd4);
    wait_done(lat);
    n_vec++;
    if ({lat, result, flag_zero, flag_sign, flag_carry} !== {32'd5, 20'h0003F, 3'b001}) begin
      n_err++;
      $display("FAIL half_shr: lat %0d res %h zsc %b expected lat 5 res 0003F zsc 001", lat, result, {flag_zero, flag_sign, flag_carry});
    end
    consume();
  endtask

  task automatic test_shamt0_cmp();
    int lat;
    start_req(OP_ADD, 1'b1, 20'hFFFFF, 20'h00001, 5'd0);
    wait_done(lat);
    consume();
    start_req(OP_SHL, 1'b1, 20'h12345, 20'h00000, 5'd0);
    wait_done(lat);
    n_vec++;
    if ({lat, result, flag_zero, flag_sign, flag_carry} !== {32'd1, 20'h12345, 3'b001}) begin
      n_err++;
      $display("FAIL shl_shamt0: lat %0d res %h zsc %b expected lat 1 res 12345 zsc 001", lat, result, {flag_zero, flag_sign, flag_carry});
    end
    consume();
    start_req(OP_CMP, 1'b1, 20'h12345, 20'h12345, 5'd0);
    wait_done(lat);
    n_vec++;
    if ({result, flag_zero, flag_sign, flag_carry} !== {20'h12345, 3'b100}) begin
      n_err++;
      $display("FAIL cmp_equal: res %h zsc %b expected res 12345 zsc 100", result, {flag_zero, flag_sign, flag_carry});
    end
    consume();
  endtask

  task automatic test_hold();
    int lat;
    int extra;
    start_req(OP_XOR, 1'b1, 20'h0F0F0, 20'h00FF0, 5'd0);
    wait_done(lat);
    op = OP_CLRF; a = 20'h00000; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      n_vec++;
      if ({out_valid, in_ready, busy, result, flag_zero, flag_sign, flag_carry} !== {3'b101, 20'h0FF00, 3'b000}) begin
        n_err++;
        $display("FAIL hold_cycle%0d: got %h expected %h", k,
                 {out_valid, in_ready, busy, result, flag_zero, flag_sign, flag_carry}, {3'b101, 20'h0FF00, 3'b000});
      end
      tick();
    end
    in_valid = 1'b0;
    consume();
    n_vec++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      n_err++;
      $display("FAIL hold_release: ov/ir/busy %b expected 010", {out_valid, in_ready, busy});
    end
    extra = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (out_valid || busy) extra++;
    end
    n_vec++;
    if (extra !== 0) begin
      n_err++;
      $display("FAIL hold_no_accept: active cycles %0d expected 0", extra);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen;
    start_req(OP_ADD, 1'b1, 20'hFFFFF, 20'h00001, 5'd0);
    wait_done(lat);
    consume();
    start_req(OP_ROL, 1'b1, 20'h80001, 20'h00000, 5'd7);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({in_ready, out_valid, busy, flag_zero, flag_sign, flag_carry} !== 6'b100000) begin
      n_err++;
      $display("FAIL reset_mid_shift: ir/ov/busy/zsc %b expected 100000",
               {in_ready, out_valid, busy, flag_zero, flag_sign, flag_carry});
    end
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (out_valid || !in_ready) seen++;
    end
    n_vec++;
    if (seen !== 0) begin
      n_err++;
      $display("FAIL reset_aborts: stray active cycles %0d expected 0", seen);
    end
    start_req(OP_INC, 1'b0, 20'h003FF, 20'h00000, 5'd0);
    wait_done(lat);
    n_vec++;
    if ({lat, result, flag_zero, flag_sign, flag_carry} !== {32'd1, 20'h00000, 3'b101}) begin
      n_err++;
      $display("FAIL post_reset_inc: lat %0d res %h zsc %b expected lat 1 res 00000 zsc 101", lat, result, {flag_zero, flag_sign, flag_carry});
    end
    consume();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = OP_NOT; mode = 1'b1; a = '0; b = '0; shamt = '0;
    tick();
    test_reset();
    tick();
    rst_n = 1'b1;
    tick();
    test_add_adc();
    test_half_sub();
    test_dec_not_clrf();
    test_rotate();
    test_long_shifts();
    test_shamt0_cmp();
    test_hold();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
